// File: rtl/nibble_pair_packer_if.sv
// Handshake bundle for nibble_pair_packer: upstream nibble stream in,
// downstream double-nibble stream out. The packer uses the slave view.
interface nibble_pair_packer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_nibble;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_double_nibble;

  modport slave (
    input  in_valid,
    input  in_nibble,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_double_nibble
  );

  modport master (
    output in_valid,
    output in_nibble,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_double_nibble
  );
endinterface

// File: rtl/nibble_pair_packer.sv
// nibble_pair_packer: pairs consecutive 4-bit nibbles into {first, second}
// bytes and buffers them in a first-word-fall-through FIFO of DEPTH entries.
// Optional feature macro: NIBBLE_PACKER_FLUSH_EN adds a flush input that
// pads a pending half pair with 4'h0 and emits it.
module nibble_pair_packer #(
  parameter int DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef NIBBLE_PACKER_FLUSH_EN
  input  logic                 flush,
`endif
  nibble_pair_packer_if.slave  bus,
  output logic [7:0]           pair_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_t;

  state_t        state;
  logic [3:0]    hold;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  logic          full;
  logic          empty;
  logic          in_rdy;
  logic          accept;
  logic          pop;
  logic          push_pair;
  logic          push_flush;
  logic          push;
  logic [7:0]    push_data;

  // Handshake decode; out_ready feeds in_ready so a full FIFO can push and pop together.
  always_comb begin
    full       = (cnt == FULL_CNT);
    empty      = (cnt == '0);
    in_rdy     = (state == S_EMPTY) | ~full | bus.out_ready;
    accept     = bus.in_valid & in_rdy;
    pop        = ~empty & bus.out_ready;
    push_pair  = (state == S_HALF) & accept;
`ifdef NIBBLE_PACKER_FLUSH_EN
    push_flush = (state == S_HALF) & flush & ~accept & (~full | bus.out_ready);
`else
    push_flush = 1'b0;
`endif
    push       = push_pair | push_flush;
    push_data  = push_pair ? {hold, bus.in_nibble} : {hold, 4'h0};
  end

  // Output view: head entry falls through, forced to zero while nothing is buffered.
  always_comb begin
    bus.in_ready          = in_rdy;
    bus.out_valid         = ~empty;
    bus.out_double_nibble = empty ? 8'h00 : mem[rd_ptr];
  end

  // Pairing FSM: EMPTY waits for a first nibble, HALF waits for the second (or a flush).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state <= S_HALF;
        S_HALF:  if (push)   state <= S_EMPTY;
        default:             state <= S_EMPTY;
      endcase
    end
  end

  // Capture the first nibble of a pair; only meaningful while in HALF.
  always_ff @(posedge clock) begin
    if ((state == S_EMPTY) && accept) hold <= bus.in_nibble;
  end

  // FIFO storage; contents are don't-care until the occupancy count covers them.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Count completed output handshakes, wrapping at 256.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pair_count <= 8'h00;
    else if (pop) pair_count <= pair_count + 8'h01;
  end

endmodule

// File: tb/tb_nibble_pair_packer.sv
// Directed self-checking bench for nibble_pair_packer (DEPTH = 2).
module tb_nibble_pair_packer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] pair_count;
  int         checks = 0;
  int         fails  = 0;
  logic [7:0] outq [$];

  nibble_pair_packer_if bus();

  nibble_pair_packer #(.DEPTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef NIBBLE_PACKER_FLUSH_EN
    .flush      (flush),
`endif
    .bus        (bus),
    .pair_count (pair_count)
  );

  always #5 clock = ~clock;

  // Record every output handshake in order.
  always @(posedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) outq.push_back(bus.out_double_nibble);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_nibble = 4'h0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    reset         = 1'b1;
    step();
    reset = 1'b0;
    step();
    outq.delete();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_nibble = 4'h0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (pair_count !== 8'h00) begin fails++; $display("FAIL reset_pair_count got %h exp 00", pair_count); end
    checks++; if (bus.out_double_nibble !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", bus.out_double_nibble); end
    step();
    reset = 1'b0;
    repeat (3) step();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL idle_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_pair();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_nibble = 4'hA;
    step();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    outq.delete();
    bus.in_valid  = 1'b1;
    bus.in_nibble = 4'h3;
    step();
    bus.in_nibble = 4'h5;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    checks++; if (outq.size() !== 1) begin fails++; $display("FAIL midreset_count got %0d exp 1", outq.size()); end
    if (outq.size() > 0) begin
      checks++; if (outq[0] !== 8'h35) begin fails++; $display("FAIL midreset_data got %h exp 35", outq[0]); end
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_nibble = 4'h1;
    step();
    bus.in_nibble = 4'h2;
    step();
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_v12 got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_double_nibble !== 8'h12) begin fails++; $display("FAIL stream_d12 got %h exp 12", bus.out_double_nibble); end
    bus.in_nibble = 4'h3;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_gap got %b exp 0", bus.out_valid); end
    bus.in_nibble = 4'h4;
    step();
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_v34 got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_double_nibble !== 8'h34) begin fails++; $display("FAIL stream_d34 got %h exp 34", bus.out_double_nibble); end
    bus.in_valid = 1'b0;
    step();
    checks++; if (pair_count !== 8'd2) begin fails++; $display("FAIL stream_pair_count got %0d exp 2", pair_count); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      bus.in_nibble = 4'(n);
      step();
    end
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_double_nibble !== 8'h12) begin fails++; $display("FAIL bp_head got %h exp 12", bus.out_double_nibble); end
    bus.in_nibble = 4'h6;
    repeat (2) step();
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_hold got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_double_nibble !== 8'h12) begin fails++; $display("FAIL bp_head_stable got %h exp 12", bus.out_double_nibble); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_release got %b exp 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL full_pushpop_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_double_nibble !== 8'h34) begin fails++; $display("FAIL full_pushpop_head got %h exp 34", bus.out_double_nibble); end
    step();
    checks++; if (bus.out_double_nibble !== 8'h56) begin fails++; $display("FAIL full_pushpop_second got %h exp 56", bus.out_double_nibble); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %b exp 0", bus.out_valid); end
    checks++; if (outq.size() !== 3) begin fails++; $display("FAIL bp_out_count got %0d exp 3", outq.size()); end
    if (outq.size() == 3) begin
      checks++; if ({outq[0], outq[1], outq[2]} !== 24'h123456) begin fails++; $display("FAIL bp_order got %h%h%h exp 123456", outq[0], outq[1], outq[2]); end
    end
    checks++; if (pair_count !== 8'd3) begin fails++; $display("FAIL bp_pair_count got %0d exp 3", pair_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.in_nibble = 4'(i);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    checks++; if (pair_count !== 8'd44) begin fails++; $display("FAIL wrap_pair_count got %0d exp 44", pair_count); end
    checks++; if (outq.size() !== 300) begin fails++; $display("FAIL wrap_out_count got %0d exp 300", outq.size()); end
    if (outq.size() == 300) begin
      checks++; if (outq[0] !== 8'h01) begin fails++; $display("FAIL wrap_first got %h exp 01", outq[0]); end
      checks++; if (outq[299] !== 8'h67) begin fails++; $display("FAIL wrap_last got %h exp 67", outq[299]); end
    end
  endtask

`ifdef NIBBLE_PACKER_FLUSH_EN
  task automatic test_flush();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_nibble = 4'hC;
    step();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL flush_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_double_nibble !== 8'hC0) begin fails++; $display("FAIL flush_data got %h exp c0", bus.out_double_nibble); end
    step();
    outq.delete();
    flush = 1'b1;
    repeat (3) step();
    flush = 1'b0;
    step();
    checks++; if (outq.size() !== 0) begin fails++; $display("FAIL flush_empty_noop got %0d exp 0", outq.size()); end
    bus.in_valid  = 1'b1;
    bus.in_nibble = 4'h9;
    step();
    bus.in_nibble = 4'h7;
    flush = 1'b1;
    step();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    repeat (3) step();
    checks++; if (outq.size() !== 1) begin fails++; $display("FAIL flush_collide_count got %0d exp 1", outq.size()); end
    if (outq.size() > 0) begin
      checks++; if (outq[0] !== 8'h97) begin fails++; $display("FAIL flush_collide_data got %h exp 97", outq[0]); end
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_nibble = 4'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_reset_mid_pair();
    test_stream();
    test_backpressure();
    test_wrap();
`ifdef NIBBLE_PACKER_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
